// File: rtl/ram_mport_pkg.sv
// Shared types and the byte-merge helper for the multi-port register-file RAM.
package ram_mport_pkg;

   typedef enum logic [0:0] {ST_CLEAR, ST_IDLE} state_e;

   localparam int unsigned DEF_DATA_WIDTH = 64;
   localparam int unsigned BE_WIDTH       = DEF_DATA_WIDTH / 8;

   // Widest word the merge helper handles; callers zero-extend narrower words.
   localparam int unsigned MAX_DATA_WIDTH = 1024;
   localparam int unsigned MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

   function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_BE_WIDTH-1:0]   be
   );
      logic [MAX_DATA_WIDTH-1:0] res;
      for (int unsigned i = 0; i < MAX_BE_WIDTH; i++) begin
         res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every address writing the init value, then idles
// until a clear request restarts the walk.
module ram_clear_seq
   import ram_mport_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  ready
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      ready   = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == '1) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            ready = 1'b1;
            if (clear) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_mport_bypass.sv
// Multi-port register-file RAM: one byte-enabled write port, NUM_RD registered
// read ports with write-first per-byte bypass, and a self-sequenced clear.
module ram_mport_bypass
   import ram_mport_pkg::*;
#(
   parameter int unsigned             ADDR_WIDTH = 6,
   parameter int unsigned             DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned             NUM_RD     = 2,
   parameter logic [DATA_WIDTH-1:0]   INIT_VALUE = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   output logic                           ready,
   input  logic                           write_en,
   input  logic [ADDR_WIDTH-1:0]          write_addr,
   input  logic [DATA_WIDTH/8-1:0]        write_be,
   input  logic [DATA_WIDTH-1:0]          write_data,
   input  logic [NUM_RD-1:0]              read_en,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   read_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   read_data,
   output logic [NUM_RD-1:0]              read_valid
);

   localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

   function automatic logic [DATA_WIDTH-1:0] merge_word(
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [NUM_BYTES-1:0]  be
   );
      logic [MAX_DATA_WIDTH-1:0] n_ext, o_ext, res;
      logic [MAX_BE_WIDTH-1:0]   b_ext;
      n_ext = '0;
      o_ext = '0;
      b_ext = '0;
      n_ext[DATA_WIDTH-1:0] = new_word;
      o_ext[DATA_WIDTH-1:0] = old_word;
      b_ext[NUM_BYTES-1:0]  = be;
      res = byte_merge(n_ext, o_ext, b_ext);
      return res[DATA_WIDTH-1:0];
   endfunction

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;

   ram_clear_seq #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_clear_seq (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .clr_we  (clr_we),
      .clr_addr(clr_addr),
      .ready   (ready)
   );

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // The clear walk owns the array while active; rst never writes storage.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = write_addr;
      mem_wdata = merge_word(write_data, mem_q[write_addr], write_be);
      if (clr_we) begin
         mem_we    = ~rst;
         mem_addr  = clr_addr;
         mem_wdata = INIT_VALUE;
      end else if (ready && write_en && !rst) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_addr] <= mem_wdata;
      end
   end

   logic [DATA_WIDTH-1:0] rd_word [NUM_RD];
   logic [DATA_WIDTH-1:0] rd_q    [NUM_RD];
   logic [NUM_RD-1:0]     valid_q;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic                  hit;
      assign addr       = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign hit        = write_en && (write_addr == addr);
      assign rd_word[p] = hit ? merge_word(write_data, mem_q[addr], write_be) : mem_q[addr];
      assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_q[p] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int unsigned p = 0; p < NUM_RD; p++) begin
            valid_q[p] <= ready && read_en[p];
            if (ready && read_en[p]) begin
               rd_q[p] <= rd_word[p];
            end
         end
      end
   end

   assign read_valid = valid_q;

endmodule

// File: tb/tb_ram_mport_bypass.sv
// Bench for ram_mport_bypass: table-driven vectors plus multi-cycle sequences,
// with a reference memory and a read scoreboard queue.
module tb_ram_mport_bypass;
   import ram_mport_pkg::*;

   localparam logic [63:0] INIT = 64'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        ready;
   logic        write_en = 1'b0;
   logic [5:0]  write_addr = '0;
   logic [BE_WIDTH-1:0] write_be = '0;
   logic [63:0] write_data = '0;
   logic [1:0]  read_en = '0;
   logic [11:0] read_addr = '0;
   logic [127:0] read_data;
   logic [1:0]  read_valid;

   ram_mport_bypass #(
      .ADDR_WIDTH(6),
      .DATA_WIDTH(64),
      .NUM_RD    (2),
      .INIT_VALUE(INIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .ready     (ready),
      .write_en  (write_en),
      .write_addr(write_addr),
      .write_be  (write_be),
      .write_data(write_data),
      .read_en   (read_en),
      .read_addr (read_addr),
      .read_data (read_data),
      .read_valid(read_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          port;
      logic [63:0] data;
   } sb_t;

   typedef struct {
      logic        we;
      logic [5:0]  wa;
      logic [7:0]  be;
      logic [63:0] wd;
      logic [1:0]  re;
      logic [5:0]  ra0;
      logic [5:0]  ra1;
      logic [63:0] e0;
      logic [63:0] e1;
   } vec_t;

   sb_t         sbq[$];
   logic [63:0] model_mem [64];
   logic [63:0] hold [2];
   bit          pend [2];
   bit          m_idle;
   int          m_cnt;
   int          total = 0;
   int          bad = 0;
   vec_t        vecs [13];

   function automatic logic [63:0] merge(input logic [63:0] nw, input logic [63:0] ow,
                                         input logic [7:0] be);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : ow[8*i +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_ports();
      for (int p = 0; p < 2; p++) begin
         if (pend[p]) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard_empty port%0d: got none expected entry", p);
            end else begin
               sb_t e = sbq.pop_front();
               hold[p] = e.data;
               chk($sformatf("valid%0d", p), 64'(read_valid[p]), 64'd1);
               chk($sformatf("data%0d", p), read_data[p*64 +: 64], e.data);
            end
            pend[p] = 1'b0;
         end else begin
            chk($sformatf("novalid%0d", p), 64'(read_valid[p]), 64'd0);
            chk($sformatf("hold%0d", p), read_data[p*64 +: 64], hold[p]);
         end
      end
   endtask

   task automatic tick(input logic we, input logic [5:0] wa, input logic [7:0] be,
                       input logic [63:0] wd, input logic [1:0] re, input logic [5:0] ra0,
                       input logic [5:0] ra1, input logic clr, input bit use_exp,
                       input logic [63:0] e0, input logic [63:0] e1);
      logic [5:0]  ra [2];
      logic [63:0] ex [2];
      logic [63:0] word;
      write_en   = we;
      write_addr = wa;
      write_be   = be;
      write_data = wd;
      read_en    = re;
      read_addr  = {ra1, ra0};
      clear      = clr;
      ra[0] = ra0;
      ra[1] = ra1;
      ex[0] = e0;
      ex[1] = e1;
      if (m_idle) begin
         for (int p = 0; p < 2; p++) begin
            if (re[p]) begin
               word = model_mem[ra[p]];
               if (we && wa == ra[p]) word = merge(wd, word, be);
               sbq.push_back('{port: p, data: use_exp ? ex[p] : word});
               pend[p] = 1'b1;
            end
         end
         if (we) model_mem[wa] = merge(wd, model_mem[wa], be);
         if (clr) begin
            m_idle = 1'b0;
            m_cnt  = 0;
         end
      end else begin
         model_mem[m_cnt] = INIT;
         m_cnt++;
         if (m_cnt == 64) m_idle = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("ready", 64'(ready), 64'(m_idle));
      check_ports();
   endtask

   task automatic idle_tick();
      tick(1'b0, '0, '0, '0, 2'b00, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b1;
      write_en = 1'b0;
      read_en  = '0;
      clear    = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      m_idle = 1'b0;
      m_cnt  = 0;
      sbq.delete();
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0;
         hold[p] = '0;
      end
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_valid", 64'(read_valid), 64'd0);
      chk("rst_data0", read_data[63:0], 64'd0);
      chk("rst_data1", read_data[127:64], 64'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 6'd5,  8'hFF, 64'h1122334455667788, 2'b00, 6'd0,  6'd0,  64'h0, 64'h0};
      vecs[1]  = '{1'b0, 6'd0,  8'h00, 64'h0, 2'b11, 6'd5, 6'd5,
                   64'h1122334455667788, 64'h1122334455667788};
      vecs[2]  = '{1'b1, 6'd9,  8'hFF, 64'hAAAAAAAAAAAAAAAA, 2'b10, 6'd0, 6'd10, 64'h0, 64'h0};
      vecs[3]  = '{1'b1, 6'd10, 8'hFF, 64'h0123456789ABCDEF, 2'b00, 6'd0, 6'd0, 64'h0, 64'h0};
      vecs[4]  = '{1'b1, 6'd9,  8'h0F, 64'h00000000BBBBBBBB, 2'b11, 6'd9, 6'd10,
                   64'hAAAAAAAABBBBBBBB, 64'h0123456789ABCDEF};
      vecs[5]  = '{1'b0, 6'd0,  8'h00, 64'h0, 2'b11, 6'd9, 6'd9,
                   64'hAAAAAAAABBBBBBBB, 64'hAAAAAAAABBBBBBBB};
      vecs[6]  = '{1'b0, 6'd0,  8'h00, 64'h0, 2'b01, 6'd5, 6'd0, 64'h1122334455667788, 64'h0};
      vecs[7]  = '{1'b1, 6'd5,  8'hFF, 64'hCAFEF00DDEADBEEF, 2'b00, 6'd5, 6'd9, 64'h0, 64'h0};
      vecs[8]  = '{1'b0, 6'd0,  8'h00, 64'h0, 2'b00, 6'd1,  6'd2,  64'h0, 64'h0};
      vecs[9]  = '{1'b0, 6'd0,  8'h00, 64'h0, 2'b00, 6'd63, 6'd62, 64'h0, 64'h0};
      vecs[10] = '{1'b1, 6'd20, 8'h00, 64'hFFFFFFFFFFFFFFFF, 2'b10, 6'd0, 6'd20, 64'h0, 64'h0};
      vecs[11] = '{1'b1, 6'd20, 8'h81, 64'hFF00000000000011, 2'b01, 6'd20, 6'd0,
                   64'hFF00000000000011, 64'h0};
      vecs[12] = '{1'b0, 6'd0,  8'h00, 64'h0, 2'b11, 6'd5, 6'd20,
                   64'hCAFEF00DDEADBEEF, 64'hFF00000000000011};

      do_reset(2);
      repeat (64) idle_tick();
      tick(1'b0, '0, '0, '0, 2'b11, 6'd0, 6'd63, 1'b0, 1'b1, 64'h0, 64'h0);

      foreach (vecs[i]) begin
         tick(vecs[i].we, vecs[i].wa, vecs[i].be, vecs[i].wd, vecs[i].re, vecs[i].ra0,
              vecs[i].ra1, 1'b0, 1'b1, vecs[i].e0, vecs[i].e1);
      end

      // Mixed traffic over a few addresses so bypass hits are frequent.
      for (int i = 0; i < 40; i++) begin
         tick(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom),
              {$urandom, $urandom}, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)),
              6'($urandom_range(0, 7)), 1'b0, 1'b0, '0, '0);
      end

      // Runtime clear with a coincident write; traffic during the walk is ignored.
      tick(1'b1, 6'd3, 8'hFF, 64'h1, 2'b00, '0, '0, 1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 64; i++) begin
         tick(1'b1, 6'($urandom_range(0, 63)), 8'hFF, {$urandom, $urandom}, 2'b11,
              6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              1'b0, '0, '0);
      end
      tick(1'b0, '0, '0, '0, 2'b11, 6'd3, 6'd5, 1'b0, 1'b1, INIT, INIT);

      // Reset in the middle of a clear walk restarts it from address 0.
      tick(1'b0, '0, '0, '0, 2'b00, '0, '0, 1'b1, 1'b0, '0, '0);
      repeat (30) idle_tick();
      do_reset(1);
      repeat (64) idle_tick();
      tick(1'b0, '0, '0, '0, 2'b11, 6'd9, 6'd63, 1'b0, 1'b1, INIT, INIT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
